// File: rtl/avk_capacitance_meter.sv
// Sums 2**AVG_LOG2 reference-toggle-to-antibounce-fall cycle counts; result valid on the edge closing the last phase.
// Holds meas_valid/meas_data stable until meas_ready; reference edges are ignored while a result waits.
module avk_capacitance_meter #(
  parameter int unsigned      CNT_W    = 16,
  parameter logic [CNT_W-1:0] TIMEOUT  = 16'd40000,
  parameter int unsigned      AVG_LOG2 = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      antibounce,
  input  logic                      reference,
  input  logic                      enable,
  output logic [CNT_W+AVG_LOG2-1:0] meas_data,
  output logic                      meas_timeout,
  output logic                      meas_valid,
  input  logic                      meas_ready,
  output logic                      busy
);

  localparam int unsigned ACC_W = CNT_W + AVG_LOG2;
  localparam int unsigned N_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [N_W-1:0] N_LAST = N_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_EDGE,
    S_MEASURE,
    S_OUTPUT
  } state_t;

  state_t             state, state_nxt;
  logic               ab_s1, ab_s, ref_s1, ref_s, ref_d;
  logic               ref_edge;
  logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc, count;
  logic [ACC_W-1:0]   acc, acc_nxt, sum, data_nxt;
  logic [N_W-1:0]     n, n_nxt;
  logic               flag, flag_nxt, tmo_nxt;
  logic               close, hit;

  // Both front-end signals are asynchronous to clock.
  always_ff @(posedge clock) begin
    if (reset) begin
      ab_s1  <= 1'b0;
      ab_s   <= 1'b0;
      ref_s1 <= 1'b0;
      ref_s  <= 1'b0;
      ref_d  <= 1'b0;
    end else begin
      ab_s1  <= antibounce;
      ab_s   <= ab_s1;
      ref_s1 <= reference;
      ref_s  <= ref_s1;
      ref_d  <= ref_s;
    end
  end

  assign ref_edge = ref_s ^ ref_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      acc          <= '0;
      n            <= '0;
      flag         <= 1'b0;
      meas_data    <= '0;
      meas_timeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      acc          <= acc_nxt;
      n            <= n_nxt;
      flag         <= flag_nxt;
      meas_data    <= data_nxt;
      meas_timeout <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    acc_nxt    = acc;
    n_nxt      = n;
    flag_nxt   = flag;
    data_nxt   = meas_data;
    tmo_nxt    = meas_timeout;
    cnt_inc    = cnt + CNT_W'(1);
    count      = '0;
    sum        = '0;
    close      = 1'b0;
    hit        = 1'b0;
    meas_valid = 1'b0;
    busy       = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        cnt_nxt  = '0;
        acc_nxt  = '0;
        n_nxt    = '0;
        flag_nxt = 1'b0;
        if (enable) state_nxt = S_WAIT_EDGE;
      end
      S_WAIT_EDGE: begin
        if (!enable) begin
          state_nxt = S_IDLE;
          acc_nxt   = '0;
          n_nxt     = '0;
          flag_nxt  = 1'b0;
        end else if (ref_edge) begin
          cnt_nxt   = '0;
          state_nxt = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (!enable) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          acc_nxt   = '0;
          n_nxt     = '0;
          flag_nxt  = 1'b0;
        end else if (ref_edge) begin
          // Early toggle: close this phase and start the next one right here.
          close   = 1'b1;
          count   = cnt;
          hit     = 1'b1;
          cnt_nxt = '0;
        end else if (!ab_s) begin
          close     = 1'b1;
          count     = cnt;
          state_nxt = S_WAIT_EDGE;
        end else if (cnt_inc == TIMEOUT) begin
          close     = 1'b1;
          count     = TIMEOUT;
          hit       = 1'b1;
          cnt_nxt   = cnt_inc;
          state_nxt = S_WAIT_EDGE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_OUTPUT: begin
        meas_valid = 1'b1;
        if (meas_ready) begin
          acc_nxt   = '0;
          n_nxt     = '0;
          flag_nxt  = 1'b0;
          state_nxt = enable ? S_WAIT_EDGE : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (close) begin
      sum      = acc + ACC_W'(count);
      acc_nxt  = sum;
      n_nxt    = n + N_W'(1);
      flag_nxt = flag | hit;
      if (n == N_LAST) begin
        data_nxt  = sum;
        tmo_nxt   = flag | hit;
        state_nxt = S_OUTPUT;
      end
    end
  end

endmodule
